reg32_shift_out: RTL and testbench
==================================

Name: reg32_shift_out

Overview:
Serial transmitter that reads a 32-bit register value (PC, IR, ALU out, etc.) from the multi-cycle datapath and shifts it out MSB-first to the board's external shift-register display chain. It captures a word on a ready/start handshake, generates sclk/sdata, then pulses slatch to update the display, and finally signals done. It is the read-out end of the datapath's clock-enabled 32-bit registers.

Parameters:
WIDTH, 32, number of bits per frame.
DIV, 2, sclk half-period in clk cycles; legal range ≥1.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request to send din; accepted only when ready=1
din  input  WIDTH  word to send; sampled only on the accept edge
ready  output  1  high when in IDLE and able to accept start
sdata  output  1  serial data, MSB first
sclk  output  1  serial clock; receiver samples on rising edge
slatch  output  1  latch strobe, high for DIV cycles after the last bit
done  output  1  one-cycle pulse at frame completion

Behaviour:
- States: IDLE, SHIFT, LATCH. ready = (state==IDLE). All other outputs are registered.
- Reset (async, takes effect immediately, including mid-frame): state=IDLE, ready=1, sdata=0, sclk=0, slatch=0, done=0, shift register=0, all counters=0. No done pulse for an aborted frame.
- Accept: at a rising edge with state==IDLE and start=1:
  - shreg<=din, sdata<=din[WIDTH-1], bitcnt<=0, divcnt<=0, phase<=0, state<=SHIFT.
  - din is don't-care after this edge.
- SHIFT: sclk=phase. divcnt counts 0..DIV-1. At divcnt==DIV-1, divcnt<=0 and:
  - phase 0→1: sclk rises; sdata stays unchanged.
  - phase 1→0 with bitcnt<WIDTH-1: shreg shifts left by 1, bitcnt++, sdata<=next bit. sdata therefore changes only when sclk falls and is stable for DIV cycles before and after each rising edge.
  - phase 1→0 with bitcnt==WIDTH-1: sclk<=0, sdata<=0, slatch<=1, state<=LATCH.
  - Each bit occupies exactly 2*DIV cycles; there are exactly WIDTH sclk rising edges per frame.
- LATCH: slatch held high for DIV cycles (divcnt 0..DIV-1). At divcnt==DIV-1: slatch<=0, done<=1, state<=IDLE.
- done is high for exactly one cycle, the same cycle in which ready returns to 1.
  - A start in that cycle is accepted (back-to-back frames, no gap cycle).
  - done deasserts on the next edge unconditionally.
- Latency: from the accept edge to the edge that raises done is 2*DIV*WIDTH + DIV cycles.
- start while ready=0 is ignored entirely: not queued, no effect on the current frame.
- Simultaneous rst and start: rst wins, and start is not captured.
- sclk, sdata and slatch are all 0 while in IDLE.

Test Plan:
1. DIV=2, WIDTH=32, start with din=0xA5A50F0F → ready drops the next cycle; 32 sclk rising edges; sampled bit stream is 1010_0101_1010_0101_0000_1111_0000_1111; slatch high for 2 cycles after the last falling edge; done pulses exactly 130 cycles after the accept edge.
2. din changes to 0xFFFFFFFF one cycle after accept, and start is pulsed mid-frame → transmitted word is still 0xA5A50F0F, no second frame starts, frame timing unchanged.
3. Back-to-back: start held high continuously with din=0x00000001 then 0x80000000 → second frame accepted in the done cycle; first stream ends ...0001, second begins 1000...; no idle cycle between slatch falling and the first bit of the second frame.
4. rst asserted 40 cycles into a frame → sclk, sdata, slatch, done go to 0 immediately (asynchronously); ready=1; no done pulse; a new start after rst release sends a correct full frame.
5. DIV=1 with din=0xDEADBEEF → each sclk level lasts 1 cycle; 32 rising edges; stream equals 0xDEADBEEF; done exactly 65 cycles after accept.
6. Reset values: check all outputs immediately after power-up rst → ready=1, sdata=0, sclk=0, slatch=0, done=0.

Source files
------------

// File: rtl/reg32_shift_out.sv
// Serial read-out of one datapath word: MSB-first sclk/sdata frame, then a slatch
// strobe and a one-cycle done pulse. Handshake below; FSM state is exported on dbg_state.
module reg32_shift_out #(
  parameter int WIDTH = 32,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             sdata,
  output logic             sclk,
  output logic             slatch,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Handshake: a frame is accepted on any rising edge where ready && start are both 1;
  // din is sampled only on that edge. start seen while ready=0 is dropped, not queued.

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [DCW-1:0] LAST_DIV = DCW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [BCW-1:0]   r_bitcnt;
  logic [DCW-1:0]   r_divcnt;
  logic             r_phase;
  logic             r_sdata;
  logic             r_slatch;
  logic             r_done;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [BCW-1:0]   w_bitcnt_nxt;
  logic [DCW-1:0]   w_divcnt_nxt;
  logic             w_phase_nxt;
  logic             w_sdata_nxt;
  logic             w_slatch_nxt;
  logic             w_done_nxt;
  logic             w_div_wrap;

  assign w_div_wrap = (r_divcnt == LAST_DIV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_divcnt <= '0;
      r_phase  <= 1'b0;
      r_sdata  <= 1'b0;
      r_slatch <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_divcnt <= w_divcnt_nxt;
      r_phase  <= w_phase_nxt;
      r_sdata  <= w_sdata_nxt;
      r_slatch <= w_slatch_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_divcnt_nxt = r_divcnt;
    w_phase_nxt  = r_phase;
    w_sdata_nxt  = r_sdata;
    w_slatch_nxt = r_slatch;
    w_done_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_shreg_nxt  = din;
          w_sdata_nxt  = din[WIDTH-1];
          w_bitcnt_nxt = '0;
          w_divcnt_nxt = '0;
          w_phase_nxt  = 1'b0;
          w_state_nxt  = SHIFT;
        end
      end

      SHIFT: begin
        if (!w_div_wrap) begin
          w_divcnt_nxt = r_divcnt + DCW'(1);
        end else begin
          w_divcnt_nxt = '0;
          if (!r_phase) begin
            w_phase_nxt = 1'b1;
          end else if (r_bitcnt != LAST_BIT) begin
            // Data only moves on the falling sclk so it is settled around each rise.
            w_phase_nxt  = 1'b0;
            w_shreg_nxt  = {r_shreg[WIDTH-2:0], 1'b0};
            w_sdata_nxt  = r_shreg[WIDTH-2];
            w_bitcnt_nxt = r_bitcnt + BCW'(1);
          end else begin
            w_phase_nxt  = 1'b0;
            w_sdata_nxt  = 1'b0;
            w_slatch_nxt = 1'b1;
            w_state_nxt  = LATCH;
          end
        end
      end

      LATCH: begin
        if (!w_div_wrap) begin
          w_divcnt_nxt = r_divcnt + DCW'(1);
        end else begin
          w_divcnt_nxt = '0;
          w_slatch_nxt = 1'b0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign ready     = (r_state == IDLE);
  assign sclk      = r_phase;
  assign sdata     = r_sdata;
  assign slatch    = r_slatch;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_reg32_shift_out.sv
// Bench for reg32_shift_out: one instance at DIV=2 and one at DIV=1, frames captured
// at sclk rises and compared with words queued from the stimulus.
module tb_reg32_shift_out;

  logic        clk;
  logic        rst;
  logic        start_a, start_b;
  logic [31:0] din_a, din_b;
  logic        ready_a, sdata_a, sclk_a, slatch_a, done_a;
  logic        ready_b, sdata_b, sclk_b, slatch_b, done_b;
  logic [1:0]  dbg_state_a, dbg_state_b;

  logic        sel;
  logic        o_ready, o_sdata, o_sclk, o_slatch, o_done;

  int compared;
  int mismatched;
  logic [31:0] exp_q[$];

  reg32_shift_out #(.WIDTH(32), .DIV(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .din(din_a),
    .ready(ready_a), .sdata(sdata_a), .sclk(sclk_a), .slatch(slatch_a),
    .done(done_a), .dbg_state(dbg_state_a)
  );

  reg32_shift_out #(.WIDTH(32), .DIV(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .din(din_b),
    .ready(ready_b), .sdata(sdata_b), .sclk(sclk_b), .slatch(slatch_b),
    .done(done_b), .dbg_state(dbg_state_b)
  );

  assign o_ready  = sel ? ready_b  : ready_a;
  assign o_sdata  = sel ? sdata_b  : sdata_a;
  assign o_sclk   = sel ? sclk_b   : sclk_a;
  assign o_slatch = sel ? slatch_b : slatch_a;
  assign o_done   = sel ? done_b   : done_a;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [31:0] d);
    if (sel) begin
      start_b = st;
      din_b   = d;
    end else begin
      start_a = st;
      din_a   = d;
    end
  endtask

  task automatic drive_start(input logic st);
    if (sel) start_b = st;
    else     start_a = st;
  endtask

  // Entered and left at a negedge. Edge 0 is the accept edge; sample k sees state after edge k.
  task automatic run_frame(input int div, input logic [31:0] word, input bit disturb,
                           input bit hold, input logic [31:0] next_word);
    int          k, rises, lat, run, bad_data, bad_level, done_k;
    bit          got;
    logic        prev_sclk, prev_sdata;
    logic [31:0] cap, expw;
    rises = 0; lat = 0; run = 0; bad_data = 0; bad_level = 0; done_k = -1; got = 0;
    prev_sclk = 1'b0; prev_sdata = 1'b0; cap = '0;

    check("ready_before_accept", {31'd0, o_ready}, 32'd1);
    drive(1'b1, word);
    exp_q.push_back(word);

    for (k = 0; k < 2 * div * 32 + div + 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("ready_drop", {31'd0, o_ready}, 32'd0);
        check("done_drop", {31'd0, o_done}, 32'd0);
        if (hold) drive(1'b1, next_word);
        else drive(1'b0, disturb ? 32'hFFFF_FFFF : $urandom());
      end
      if (disturb && !hold && k == 40) drive_start(1'b1);
      if (disturb && !hold && k == 41) drive_start(1'b0);

      if (k > 0 && o_sdata !== prev_sdata && !(prev_sclk && !o_sclk)) bad_data++;
      if (o_slatch && (o_sdata || o_sclk)) bad_data++;
      if (k > 0 && o_sclk !== prev_sclk) begin
        if (run != div) bad_level++;
        run = 0;
      end
      run++;
      if (o_sclk && !prev_sclk) begin
        rises++;
        cap = {cap[30:0], o_sdata};
      end
      if (o_slatch) lat++;
      prev_sclk  = o_sclk;
      prev_sdata = o_sdata;
      if (o_done) begin
        got = 1;
        done_k = k;
        break;
      end
    end

    expw = exp_q.pop_front();
    check("done_seen", {31'd0, got}, 32'd1);
    check("done_latency", done_k, 2 * div * 32 + div);
    check("sclk_rises", rises, 32);
    check("slatch_width", lat, div);
    check("sdata_stability", bad_data, 0);
    check("sclk_level_len", bad_level, 0);
    check("stream_word", cap, expw);
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("idle_done_low", {31'd0, o_done}, 32'd0);
    check("idle_ready", {31'd0, o_ready}, 32'd1);
    check("idle_sclk", {31'd0, o_sclk}, 32'd0);
    check("idle_sdata", {31'd0, o_sdata}, 32'd0);
    check("idle_slatch", {31'd0, o_slatch}, 32'd0);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    sel = 1'b0;
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    din_a = '0; din_b = '0;

    // power-up reset values on both instances
    #1;
    check("por_ready_a", {31'd0, ready_a}, 32'd1);
    check("por_sdata_a", {31'd0, sdata_a}, 32'd0);
    check("por_sclk_a", {31'd0, sclk_a}, 32'd0);
    check("por_slatch_a", {31'd0, slatch_a}, 32'd0);
    check("por_done_a", {31'd0, done_a}, 32'd0);
    check("por_ready_b", {31'd0, ready_b}, 32'd1);
    check("por_done_b", {31'd0, done_b}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // directed frame, then the same word with din/start disturbed mid-frame
    run_frame(2, 32'hA5A5_0F0F, 1'b0, 1'b0, 32'h0);
    idle_check();
    run_frame(2, 32'hA5A5_0F0F, 1'b1, 1'b0, 32'h0);
    idle_check();

    // back-to-back with start held high through the first frame
    run_frame(2, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000);
    run_frame(2, 32'h8000_0000, 1'b0, 1'b0, 32'h0);
    idle_check();

    // asynchronous reset 40 cycles into a frame
    drive(1'b1, 32'h1234_5678);
    @(negedge clk);
    drive(1'b0, 32'h0);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_sclk", {31'd0, o_sclk}, 32'd0);
    check("rst_sdata", {31'd0, o_sdata}, 32'd0);
    check("rst_slatch", {31'd0, o_slatch}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_done_after_abort", {31'd0, o_done}, 32'd0);
    end
    run_frame(2, $urandom(), 1'b0, 1'b0, 32'h0);
    idle_check();

    // DIV=1 instance
    sel = 1'b1;
    run_frame(1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    idle_check();

    // randomized frames on both instances
    for (int i = 0; i < 6; i++) begin
      sel = i[0];
      run_frame(sel ? 1 : 2, $urandom(), 1'($urandom_range(0, 1)), 1'b0, 32'h0);
      idle_check();
    end

    // rst and start together: start must not be captured
    sel = 1'b0;
    rst = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF);
    @(negedge clk);
    check("rst_start_ready", {31'd0, o_ready}, 32'd1);
    drive(1'b0, 32'h0);
    rst = 1'b0;
    idle_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
